// File: rtl/vga_scan_out.sv
// vga_scan_out: 640x480@60 VGA timing generator and frame-buffer scan-out.
// Counter stage S0 drives a linear BRAM read address (S1). BRAM data returns
// in S2, and all pins are registered together in S3, three edges after S0.
module vga_scan_out #(
    parameter int DW       = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pattern_en,
    output logic [18:0]   o_vga_addr,
    input  logic [DW-1:0] i_vga_data,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [DW-1:0] o_rgb,
    output logic          o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int SW      = $clog2(BAR_W + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(BAR_W - 1);
    localparam logic [18:0]   PIX_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    // S0 state
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [2:0]    bar_q, bar_d;
    logic          pat_q, pat_d;
    logic [18:0]   pix_q, pix_d;

    logic          vis, frame0, pat_now, hs_act, vs_act;
    logic [DW-1:0] bar_rgb;

    // S1 / S2 / S3 pipeline
    logic [18:0]   addr_q;
    logic          de1_q, hs1_q, vs1_q, fs1_q, pat1_q;
    logic [DW-1:0] bar1_q;
    logic          de2_q, hs2_q, vs2_q, fs2_q, pat2_q;
    logic [DW-1:0] bar2_q;
    logic          de3_q, hs3_q, vs3_q, fs3_q;
    logic [DW-1:0] rgb3_q;

    // Decode the current raster position and pick this pixel's bar colour
    always_comb begin
        vis     = (h_q < H_VIS) && (v_q < V_VIS);
        frame0  = (h_q == '0) && (v_q == '0);
        // pixel (0,0) must already see the newly sampled enable
        pat_now = frame0 ? i_pattern_en : pat_q;
        hs_act  = (h_q >= HS_BEG) && (h_q <= HS_END);
        vs_act  = (v_q >= VS_BEG) && (v_q <= VS_END);
        // bar order W,Y,C,G,M,R,B,K gives R=~b1, G=~b2, B=~b0
        bar_rgb             = '0;
        bar_rgb[DW-1:DW-4]  = {4{~bar_q[1]}};
        bar_rgb[DW-5:4]     = {(DW-8){~bar_q[2]}};
        bar_rgb[3:0]        = {4{~bar_q[0]}};
    end

    // Next-state for raster counters, bar sub-counter and pixel address
    always_comb begin
        h_d   = h_q + 1'b1;
        v_d   = v_q;
        sub_d = sub_q + 1'b1;
        bar_d = bar_q;
        if (h_q == H_LAST) begin
            h_d   = '0;
            v_d   = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            sub_d = '0;
            bar_d = '0;
        end else if (sub_q == SUB_LAST) begin
            sub_d = '0;
            bar_d = bar_q + 1'b1;
        end
        pat_d = pat_now;
        pix_d = pix_q;
        if (vis) begin
            pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + 19'd1;
        end
    end

    // S0: raster counters and frame-latched pattern enable
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_q   <= '0;
            v_q   <= '0;
            sub_q <= '0;
            bar_q <= '0;
            pat_q <= 1'b0;
            pix_q <= '0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            sub_q <= sub_d;
            bar_q <= bar_d;
            pat_q <= pat_d;
            pix_q <= pix_d;
        end
    end

    // S1: issue BRAM address and capture the position's control bits
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q <= '0;
            de1_q  <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            fs1_q  <= 1'b0;
            pat1_q <= 1'b0;
            bar1_q <= '0;
        end else begin
            if (vis) begin
                addr_q <= pix_q;
            end
            de1_q  <= vis;
            hs1_q  <= ~hs_act;
            vs1_q  <= ~vs_act;
            fs1_q  <= frame0;
            pat1_q <= pat_now;
            bar1_q <= bar_rgb;
        end
    end

    // S2: delay control bits while BRAM performs its registered read
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            de2_q  <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            fs2_q  <= 1'b0;
            pat2_q <= 1'b0;
            bar2_q <= '0;
        end else begin
            de2_q  <= de1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            fs2_q  <= fs1_q;
            pat2_q <= pat1_q;
            bar2_q <= bar1_q;
        end
    end

    // S3: register all pin outputs together, blanking RGB outside DE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            de3_q  <= 1'b0;
            hs3_q  <= 1'b1;
            vs3_q  <= 1'b1;
            fs3_q  <= 1'b0;
            rgb3_q <= '0;
        end else begin
            de3_q  <= de2_q;
            hs3_q  <= hs2_q;
            vs3_q  <= vs2_q;
            fs3_q  <= fs2_q;
            rgb3_q <= de2_q ? (pat2_q ? bar2_q : i_vga_data) : '0;
        end
    end

    assign o_vga_addr    = addr_q;
    assign o_de          = de3_q;
    assign o_hsync       = hs3_q;
    assign o_vsync       = vs3_q;
    assign o_frame_start = fs3_q;
    assign o_rgb         = rgb3_q;

endmodule

// File: doc/vga_scan_out.md
Name: vga_scan_out

Overview:
- Downstream neighbour of the pixel frame buffer, running in the 25 MHz pixel clock domain.
- Generates 640x480@60 Hz VGA timing and a linear read address into the frame-buffer BRAM.
- Receives the BRAM read data and drives registered, pipeline-aligned RGB, sync and data-enable to the DAC/pins.
- Optional built-in colour-bar pattern for bring-up.

Parameters:
DW, 12, pixel width (4:4:4 RGB, R in [DW-1:DW-4], B in [3:0])
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch

Ports:
i_clk  in  1  pixel clock, 25 MHz
i_rst  in  1  asynchronous active-high reset
i_pattern_en  in  1  1 = colour bars, 0 = frame-buffer data
o_vga_addr  out  19  frame-buffer read address
i_vga_data  in  DW  frame-buffer read data; valid exactly 1 cycle after o_vga_addr
o_hsync  out  1  horizontal sync, active low
o_vsync  out  1  vertical sync, active low
o_de  out  1  data enable, high during visible pixels
o_rgb  out  DW  pixel output; 0 when o_de=0
o_frame_start  out  1  one-cycle pulse aligned with the first visible pixel of each frame

Behaviour:
- Reset (async assert, sync release): h_cnt=0, v_cnt=0, o_vga_addr=0, o_hsync=1, o_vsync=1, o_de=0, o_rgb=0, o_frame_start=0. All pipeline stages are cleared. Reset mid-line or mid-frame restarts from (0,0) on the first edge after release.
- Counters (stage S0):
  - h_cnt runs 0..799; wraps to 0.
  - v_cnt increments when h_cnt=799; runs 0..524; wraps to 0 at (799,524).
  - Visible region: h<640 and v<480.
  - hsync asserted for h in 656..751; vsync asserted for v in 490..491.
- Address (stage S1):
  - A 19-bit running pixel counter is registered onto o_vga_addr and increments by 1 after each visible pixel is issued.
  - At (639,479) it wraps to 0 (307199 -> 0).
  - Outside the visible region the address holds its value; no multiplier is used.
  - Pixel (h,v) is presented on o_vga_addr one edge after the counter holds (h,v).
- Data (stage S2): i_vga_data is valid one edge after the address (BRAM registered-read latency = 1).
- Output (stage S3): o_rgb, o_de, o_hsync, o_vsync and o_frame_start are all registered together.
- Latency: the output for counter state (h,v) at edge k appears at edge k+3. Sync and data-enable are delayed by a matching shift chain, so all outputs stay aligned.
- o_rgb:
  - Equals i_vga_data when de=1 and the pattern is off.
  - Equals the bar colour when the pattern is on.
  - Forced to 0 when de=0.
- Pattern:
  - 8 bars of 80 px each, in order: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - Bar index is h_cnt/80, computed with a 0..79 sub-counter; no divider.
- Pattern enable: i_pattern_en is sampled only when the counters hold (0,0). A change mid-frame takes effect at the next frame, so a frame is never torn.
- o_frame_start: high for exactly one cycle, coincident with o_de rising for pixel (0,0).
- Frame period: 800*525 = 420000 cycles.

Test Plan:
- Reset: hold i_rst for 5 cycles at random phase → o_hsync=1, o_vsync=1, o_de=0, o_rgb=0, o_vga_addr=0. The first o_de=1 occurs at edge 3 after release.
- Line timing: count cycles after release → o_de high for 640 cycles, then o_hsync low for 96 cycles starting 16 cycles after o_de falls. Line period is 800 cycles.
- Frame timing: run 2 frames → o_vsync low for exactly 1600 cycles per frame. o_frame_start pulses are 420000 cycles apart.
- Address and data alignment: drive i_vga_data = previous o_vga_addr[11:0] → o_rgb equals the address of each visible pixel. The address reaches 307199, then reads 0 on the next frame's first pixel.
- Pattern: assert i_pattern_en mid-frame → the current frame still shows BRAM data. The next frame shows FFF for pixels 0..79, FF0 for 80..159, and 000 for 560..639.
- Reset mid-operation: assert i_rst at (h=300,v=200) → outputs return to reset values immediately (async). After release, timing restarts at (0,0) and the address starts at 0.
